spi_channel_scheduler: RTL
==========================

SPI_CHANNEL_SCHEDULER -- requirements
Module: spi_channel_scheduler

Interface
REQ-001 Parameter NUM_SLAVES, default 8: slave count, legal 1..16.
REQ-002 Parameter ADDR_W, default 8: slave-queue address width.
REQ-003 Parameter STAT_BASE, default 8'h10: status-register base address.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: wait limit in HALT and FINISH; legal 2..65535.
REQ-005 Parameter SEL_ACTIVE_LOW, default 1: select polarity (1 = active-low).
REQ-006 One clock, ACLK; reset is synchronous and active-high, named reset.
REQ-007 ACLK  in  1  system clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 SSQ_empty  in  1  slave-select queue empty.
REQ-010 rd_en  out  1  queue pop strobe.
REQ-011 rd_slave_addr  in  ADDR_W  queue data, valid the cycle after rd_en.
REQ-012 tx_reg_addr  out  ADDR_W  TX register address for the current transfer.
REQ-013 rx_reg_en / rx_reg_addr  out  1 / ADDR_W  RX capture strobe and address.
REQ-014 wr_stat_up_en / wr_stat_up_addr  out  1 / ADDR_W  write-status update.
REQ-015 rd_stat_up, rd_stat_up_en, rd_stat_up_addr  out  1, 1, ADDR_W  read-status value, strobe and address.
REQ-016 SPI_start  out  1  SPI engine start.
REQ-017 SPI_select  out  NUM_SLAVES  chip selects; bit i selects slave i.
REQ-018 SPI_busy  in  1  SPI engine busy.
REQ-019 sclk_rise  in  1  single-ACLK pulse marking the first SCLK rising edge.
REQ-020 err_en / err_code  out  1 / 2  error strobe and code.
REQ-021 xfer_count  out  16  count of completed transfers.

Function
REQ-022 States: IDLE, FETCH, DECODE, START, HALT, FINISH, ERROR.
REQ-023 IDLE: when !SSQ_empty && !SPI_busy, pulse rd_en for one cycle and go to FETCH; otherwise rd_en=0.
REQ-024 FETCH: latch rd_slave_addr as A; drive tx_reg_addr=A; go to DECODE.
REQ-025 DECODE: if A is odd or A>>1 >= NUM_SLAVES, go to ERROR with err_code=2'b01; otherwise go to START.
REQ-026 START: SPI_start=1; assert only SPI_select bit A>>1; one-cycle pulse of rd_stat_up_en with rd_stat_up=0 and rd_stat_up_addr=STAT_BASE+A+1; clear the timer; go to HALT.
REQ-027 HALT: on sclk_rise, drop SPI_start, pulse wr_stat_up_en for one cycle with wr_stat_up_addr=STAT_BASE+A, clear the timer, and go to FINISH.
REQ-028 FINISH: on !SPI_busy, pulse rd_stat_up_en for one cycle (rd_stat_up=1, addr STAT_BASE+A+1) and rx_reg_en (rx_reg_addr=A+1); increment xfer_count; go to IDLE.
REQ-029 Timer: counts ACLK cycles in HALT and FINISH; reaching TIMEOUT_CYCLES-1 goes to ERROR with code 2'b10 (HALT) or 2'b11 (FINISH); sclk_rise or !SPI_busy in that same cycle wins over the timeout.
REQ-030 ERROR: SPI_start=0; all selects inactive; one-cycle err_en with err_code held; go to IDLE. No status or rx strobes are issued.
REQ-031 SPI_select stays asserted from START through the FINISH exit and is inactive in all other states.
REQ-032 Address arithmetic is modulo 2^ADDR_W; xfer_count wraps from 16'hFFFF to 0.
REQ-033 Minimum IDLE-to-IDLE latency is 6 cycles when sclk_rise and !SPI_busy arrive on the first eligible cycles; back-to-back transfers need no idle gap beyond the IDLE cycle.

Reset
REQ-034 Reset puts the block in IDLE with all strobes 0, all addresses 0, rd_stat_up=0, SPI_start=0, SPI_select all inactive (all 1s when SEL_ACTIVE_LOW=1), err_code=0, xfer_count=0 and the timer 0.
REQ-035 Reset in any state takes effect at the next ACLK edge and abandons any in-flight transfer without strobes.

Structure
REQ-036 A shared package holds the state enum, the err_code constants and the default STAT_BASE.
REQ-037 Sub-module spi_sel_decoder (index -> one-hot with polarity) is the natural split; the timer stays inline.

Verification
REQ-038 Queue holds 8'h04, sclk_rise 3 cycles after START, SPI_busy low 10 cycles later -> SPI_select=8'b1111_1011, wr_stat_up_addr=8'h14, rd_stat_up_addr=8'h15, rx_reg_addr=8'h05, xfer_count=1.
REQ-039 Queue holds 8'h03 -> err_en pulse with err_code=01, SPI_start never asserted, rd_en exactly once.
REQ-040 TIMEOUT_CYCLES=4, no sclk_rise -> ERROR 4 cycles after HALT entry, err_code=10, selects inactive.
REQ-041 SPI_busy stuck high after sclk_rise -> err_code=11; then queue 8'h0E completes normally on slave 7.
REQ-042 NUM_SLAVES=4 with address 8'h08 -> err_code=01; reset asserted mid-HALT -> outputs return to reset values at the next edge.

Source files
------------

// File: rtl/spi_channel_scheduler_pkg.sv
// spi_channel_scheduler_pkg: shared state codes, error codes and default status base.
package spi_channel_scheduler_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_START  = 3'd3;
  localparam state_t S_HALT   = 3'd4;
  localparam state_t S_FINISH = 3'd5;
  localparam state_t S_ERROR  = 3'd6;
  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ADDR   = 2'b01;
  localparam logic [1:0] ERR_HALT   = 2'b10;
  localparam logic [1:0] ERR_FINISH = 2'b11;
  localparam logic [7:0] DEF_STAT_BASE = 8'h10;
endpackage

// File: rtl/spi_channel_scheduler_sel_decoder.sv
// spi_sel_decoder: slave index to one-hot chip selects with configurable polarity.
module spi_sel_decoder #(
  parameter int N = 8,
  parameter int IDX_W = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     sel
);
  for (genvar i = 0; i < N; i++) begin : g_sel
    assign sel[i] = (en && idx == IDX_W'(i)) ^ (ACTIVE_LOW != 0);
  end
endmodule

// File: rtl/spi_channel_scheduler.sv
// spi_channel_scheduler: pops slave addresses, runs one SPI transfer each and reports status/errors.
module spi_channel_scheduler
  import spi_channel_scheduler_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] STAT_BASE = ADDR_W'(DEF_STAT_BASE),
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  ACLK,
  input  logic                  reset,
  input  logic                  SSQ_empty,
  output logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_slave_addr,
  output logic [ADDR_W-1:0]     tx_reg_addr,
  output logic                  rx_reg_en,
  output logic [ADDR_W-1:0]     rx_reg_addr,
  output logic                  wr_stat_up_en,
  output logic [ADDR_W-1:0]     wr_stat_up_addr,
  output logic                  rd_stat_up,
  output logic                  rd_stat_up_en,
  output logic [ADDR_W-1:0]     rd_stat_up_addr,
  output logic                  SPI_start,
  output logic [NUM_SLAVES-1:0] SPI_select,
  input  logic                  SPI_busy,
  input  logic                  sclk_rise,
  output logic                  err_en,
  output logic [1:0]            err_code,
  output logic [15:0]           xfer_count
);
  state_t state, state_n;
  logic [ADDR_W-1:0] a_q, slot, a_inc;
  logic [15:0] timer;
  logic go, bad, tmo, done, live;
  logic [1:0] code;
  assign slot  = a_q >> 1;
  assign a_inc = a_q + ADDR_W'(1);
  assign go    = state == S_IDLE && !SSQ_empty && !SPI_busy && !reset;
  assign bad   = a_q[0] || slot >= ADDR_W'(NUM_SLAVES);
  assign tmo   = timer == 16'(TIMEOUT_CYCLES - 1);
  assign done  = state == S_FINISH && !SPI_busy;
  assign live  = state == S_START || state == S_HALT || state == S_FINISH;
  assign code  = state == S_DECODE ? ERR_ADDR : state == S_HALT ? ERR_HALT : ERR_FINISH;
  // Addresses read as zero whenever their strobe is idle.
  assign rd_en           = go;
  assign tx_reg_addr     = state == S_FETCH ? rd_slave_addr : a_q;
  assign rx_reg_en       = done;
  assign rx_reg_addr     = done ? a_inc : '0;
  assign wr_stat_up_en   = state == S_HALT && sclk_rise;
  assign wr_stat_up_addr = wr_stat_up_en ? STAT_BASE + a_q : '0;
  assign rd_stat_up_en   = state == S_START || done;
  assign rd_stat_up      = done;
  assign rd_stat_up_addr = rd_stat_up_en ? STAT_BASE + a_inc : '0;
  assign SPI_start       = state == S_START || state == S_HALT;
  assign err_en          = state == S_ERROR;
  spi_sel_decoder #(
    .N(NUM_SLAVES),
    .IDX_W(ADDR_W),
    .ACTIVE_LOW(SEL_ACTIVE_LOW)
  ) u_sel (
    .en(live),
    .idx(slot),
    .sel(SPI_select)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = go ? S_FETCH : S_IDLE;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: state_n = bad ? S_ERROR : S_START;
      S_START:  state_n = S_HALT;
      S_HALT:   state_n = sclk_rise ? S_FINISH : tmo ? S_ERROR : S_HALT;
      S_FINISH: state_n = !SPI_busy ? S_IDLE : tmo ? S_ERROR : S_FINISH;
      default:  state_n = S_IDLE;
    endcase
  end
  // The timer runs only while a wait state is held and restarts on every state change.
  always_ff @(posedge ACLK) begin
    if (reset) begin
      state      <= S_IDLE;
      a_q        <= '0;
      timer      <= '0;
      err_code   <= ERR_NONE;
      xfer_count <= '0;
    end else begin
      state <= state_n;
      if (state == S_FETCH) a_q <= rd_slave_addr;
      timer <= (state_n == state && (state == S_HALT || state == S_FINISH)) ? timer + 16'd1 : '0;
      if (state_n == S_ERROR) err_code <= code;
      if (done) xfer_count <= xfer_count + 16'd1;
    end
  end
endmodule
